// File: rtl/mem_ctrl.sv
// Byte-serial load/store responder between the MEM-stage access unit and a byte-wide RAM.
// Little-endian sequencing; load data assembled zero-extended with a one-cycle RAM read latency.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              mac_req,
  input  logic              mac_wr,
  input  logic [ADDR_W-1:0] mac_a,
  input  logic [3:0]        mac_kind,
  input  logic [31:0]       mac_dout,
  output logic              mac_busy,
  output logic              mac_done,
  output logic [31:0]       mac_din,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] a_reg;
  logic [31:0]       dout_reg;
  logic [2:0]        k_reg;
  logic [2:0]        cnt_reg;
  logic [1:0]        cap_reg;
  logic              primed_reg;
  logic              ram_wr_reg;
  logic [7:0]        dout_byte [4];

  function automatic logic [2:0] kind_bytes(input logic [3:0] kind);
    case (kind)
      4'b0001: kind_bytes = 3'd1;
      4'b0010: kind_bytes = 3'd2;
      4'b0100: kind_bytes = 3'd4;
      default: kind_bytes = 3'd0;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign dout_byte[gi] = dout_reg[8*gi +: 8];
  end

  // The RAM is frozen by the same rdy, so a held write strobe must not fire while paused.
  assign ram_wr = ram_wr_reg & rdy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      dout_reg   <= '0;
      k_reg      <= '0;
      cnt_reg    <= '0;
      cap_reg    <= '0;
      primed_reg <= 1'b0;
      ram_wr_reg <= 1'b0;
      mac_busy   <= 1'b0;
      mac_done   <= 1'b0;
      mac_din    <= '0;
      ram_a      <= '0;
      ram_dout   <= '0;
    end else if (rdy) begin
      case (state_reg)
        IDLE: begin
          if (mac_req) begin
            a_reg      <= mac_a;
            dout_reg   <= mac_dout;
            k_reg      <= kind_bytes(mac_kind);
            mac_din    <= '0;
            cap_reg    <= '0;
            primed_reg <= 1'b0;
            if (kind_bytes(mac_kind) == 3'd0) begin
              state_reg <= DONE;
              mac_done  <= 1'b1;
            end else begin
              mac_busy <= 1'b1;
              ram_a    <= mac_a;
              cnt_reg  <= 3'd1;
              if (mac_wr) begin
                state_reg  <= WRITE;
                ram_wr_reg <= 1'b1;
                ram_dout   <= mac_dout[7:0];
              end else begin
                state_reg <= READ;
              end
            end
          end
        end
        WRITE: begin
          if (cnt_reg == k_reg) begin
            state_reg  <= DONE;
            ram_wr_reg <= 1'b0;
            mac_busy   <= 1'b0;
            mac_done   <= 1'b1;
          end else begin
            ram_a    <= a_reg + ADDR_W'(cnt_reg);
            ram_dout <= dout_byte[cnt_reg[1:0]];
            cnt_reg  <= cnt_reg + 3'd1;
          end
        end
        READ: begin
          if (cnt_reg != k_reg) begin
            ram_a   <= a_reg + ADDR_W'(cnt_reg);
            cnt_reg <= cnt_reg + 3'd1;
          end
          // ram_din carries the byte addressed one cycle earlier, so capture starts one cycle late.
          if (primed_reg) begin
            mac_din[{cap_reg, 3'b000} +: 8] <= ram_din;
            cap_reg <= cap_reg + 2'd1;
            if ({1'b0, cap_reg} == k_reg - 3'd1) begin
              state_reg <= DONE;
              mac_busy  <= 1'b0;
              mac_done  <= 1'b1;
            end
          end
          primed_reg <= 1'b1;
        end
        DONE: begin
          mac_done  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level model expanded into expected per-cycle outputs,
// a pin-level RAM, directed cases with literal expectations and a randomized phase.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, mac_req, mac_wr;
  logic [31:0] mac_a, mac_dout, mac_din, ram_a;
  logic [3:0]  mac_kind;
  logic        mac_busy, mac_done, ram_wr;
  logic [7:0]  ram_din, ram_dout;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mac_req(mac_req), .mac_wr(mac_wr), .mac_a(mac_a), .mac_kind(mac_kind),
    .mac_dout(mac_dout), .mac_busy(mac_busy), .mac_done(mac_done), .mac_din(mac_din),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );

  logic [7:0] ram_mem   [logic [31:0]];
  logic [7:0] model_mem [logic [31:0]];

  function automatic logic [7:0] rd_ram(input logic [31:0] ad);
    return ram_mem.exists(ad) ? ram_mem[ad] : 8'h00;
  endfunction

  function automatic logic [7:0] rd_model(input logic [31:0] ad);
    return model_mem.exists(ad) ? model_mem[ad] : 8'h00;
  endfunction

  function automatic int kbytes(input logic [3:0] kd);
    case (kd)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic poke(input logic [31:0] ad, input logic [7:0] v);
    ram_mem[ad] = v;
    model_mem[ad] = v;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Pin-level RAM: one-cycle read latency, frozen together with the controller by rdy.
  initial begin
    logic [31:0] ad;
    ram_din = 8'h00;
    forever begin
      @(posedge clk);
      if (rdy) begin
        ad = ram_a;
        if (ram_wr) ram_mem[ad] = ram_dout;
        ram_din <= rd_ram(ad);
      end
    end
  end

  // Model: each accepted request becomes the list of outputs it must show on each active cycle.
  typedef struct packed {
    logic        busy, done, wr, dinchk;
    logic [31:0] a;
    logic [7:0]  dout;
    logic [31:0] din;
  } ent_t;

  ent_t cur;
  ent_t q[$];
  bit   started = 0;

  initial begin
    ent_t e, h;
    int k;
    logic [31:0] d, ad, sh;
    forever begin
      @(posedge clk);
      if (!rst) begin
        q.delete();
        cur = '0;
        cur.dinchk = 1'b1;
      end else if (rdy) begin
        if (q.size() > 0) begin
          cur = q.pop_front();
        end else if (cur.done) begin
          cur.done = 1'b0;
        end else if (!cur.busy && mac_req) begin
          k = kbytes(mac_kind);
          h = cur;
          if (k == 0) begin
            e = '0; e.done = 1'b1; e.a = h.a; e.dout = h.dout; e.dinchk = 1'b1;
            q.push_back(e);
          end else if (mac_wr) begin
            for (int i = 0; i < k; i++) begin
              e = '0; e.busy = 1'b1; e.wr = 1'b1;
              ad = mac_a + 32'(i);
              sh = mac_dout >> (8 * i);
              e.a = ad; e.dout = sh[7:0];
              model_mem[ad] = sh[7:0];
              q.push_back(e);
            end
            e.busy = 1'b0; e.wr = 1'b0; e.done = 1'b1;
            q.push_back(e);
          end else begin
            d = '0;
            for (int i = 0; i < k; i++) begin
              ad = mac_a + 32'(i);
              d = d | (32'(rd_model(ad)) << (8 * i));
              e = '0; e.busy = 1'b1; e.a = ad; e.dout = h.dout;
              q.push_back(e);
            end
            q.push_back(e);
            e.busy = 1'b0; e.done = 1'b1; e.dinchk = 1'b1; e.din = d;
            q.push_back(e);
          end
          cur = q.pop_front();
        end
      end
      started = 1;
    end
  end

  // Every-cycle comparison of the DUT pins against the model.
  initial begin
    logic ok;
    forever begin
      @(negedge clk);
      if (started) begin
        ok = (mac_busy === cur.busy) && (mac_done === cur.done) &&
             (ram_wr === (cur.wr & rdy)) && (ram_a === cur.a) && (ram_dout === cur.dout) &&
             (!cur.dinchk || (mac_din === cur.din));
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL cycle t=%0t busy=%b/%b done=%b/%b wr=%b/%b a=%h/%h dout=%h/%h din=%h/%h(chk=%b)",
                   $time, mac_busy, cur.busy, mac_done, cur.done, ram_wr, cur.wr & rdy,
                   ram_a, cur.a, ram_dout, cur.dout, mac_din, cur.din, cur.dinchk);
        end
      end
    end
  end

  // Directed request; cycle numbers count from the accept edge, rdy low during cycles lo..hi.
  task automatic run_req(input logic wr, input logic [31:0] a, input logic [3:0] kind,
                         input logic [31:0] dout, input int exp_cyc, input bit chk_din,
                         input logic [31:0] exp_din, input int lo, input int hi);
    int n;
    @(posedge clk);
    #1;
    mac_req = 1'b1; mac_wr = wr; mac_a = a; mac_kind = kind; mac_dout = dout; rdy = 1'b1;
    @(posedge clk);
    n = 1;
    #1;
    mac_a = $urandom; mac_dout = $urandom;
    rdy = !(n >= lo && n <= hi);
    forever begin
      @(negedge clk);
      if (mac_done) break;
      if (n >= 60) begin
        chk("done_timeout", 32'(n), 32'(exp_cyc));
        break;
      end
      @(posedge clk);
      n++;
      #1 rdy = !(n >= lo && n <= hi);
    end
    mac_req = 1'b0;
    rdy = 1'b1;
    chk("done_cycle", 32'(n), 32'(exp_cyc));
    if (chk_din) chk("din", mac_din, exp_din);
  endtask

  task automatic rand_txn();
    int r, n;
    logic [3:0] bk [4];
    bk[0] = 4'b0000; bk[1] = 4'b0011; bk[2] = 4'b1000; bk[3] = 4'b1111;
    @(posedge clk);
    #1;
    mac_req = 1'b1;
    mac_wr = 1'($urandom_range(0, 1));
    mac_a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                        : 32'h1000 + 32'($urandom_range(0, 63));
    r = $urandom_range(0, 9);
    mac_kind = (r < 3) ? 4'b0001 : (r < 6) ? 4'b0010 : (r < 9) ? 4'b0100 : bk[$urandom_range(0, 3)];
    mac_dout = $urandom;
    rdy = ($urandom_range(0, 4) != 0);
    n = 0;
    forever begin
      @(negedge clk);
      if (mac_done) break;
      if (n >= 100) begin
        chk("rand_timeout", 32'(n), 32'd0);
        break;
      end
      @(posedge clk);
      n++;
      #1 rdy = ($urandom_range(0, 4) != 0);
    end
    mac_req = 1'b0;
  endtask

  initial begin
    int dn;
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    rst = 1'b0; rdy = 1'b1; mac_req = 1'b0; mac_wr = 1'b0;
    mac_a = '0; mac_kind = '0; mac_dout = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(mac_busy), 32'd0);
    chk("rst_done", 32'(mac_done), 32'd0);
    chk("rst_din", mac_din, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    poke(32'h7, 8'h80); poke(32'h21, 8'h5A);

    run_req(1'b0, 32'h100, 4'b0100, 32'h0, 6, 1, 32'h44332211, 0, -1);
    run_req(1'b1, 32'h20, 4'b0001, 32'h123456A5, 2, 0, 32'h0, 0, -1);
    run_req(1'b1, 32'hFFFF_FFFF, 4'b0010, 32'h0000BEEF, 3, 0, 32'h0, 0, -1);
    run_req(1'b0, 32'h7, 4'b0001, 32'h0, 3, 1, 32'h00000080, 0, -1);
    run_req(1'b0, 32'h100, 4'b0100, 32'h0, 8, 1, 32'h44332211, 2, 3);
    run_req(1'b0, 32'h40, 4'b1000, 32'h0, 1, 1, 32'h0, 0, -1);
    chk("mem_sb", 32'(rd_ram(32'h20)), 32'hA5);
    chk("mem_sb_neighbour", 32'(rd_ram(32'h21)), 32'h5A);
    chk("mem_sh_lo", 32'(rd_ram(32'hFFFF_FFFF)), 32'hEF);
    chk("mem_sh_hi", 32'(rd_ram(32'h0)), 32'hBE);

    // Store abandoned by reset during its second cycle.
    @(posedge clk);
    #1 mac_req = 1'b1; mac_wr = 1'b1; mac_a = 32'h300; mac_kind = 4'b0100; mac_dout = 32'hCAFEF00D;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1; mac_req = 1'b0;
    @(negedge clk);
    chk("abort_ram_wr", 32'(ram_wr), 32'd0);
    chk("abort_busy", 32'(mac_busy), 32'd0);
    chk("abort_ram_a", ram_a, 32'd0);
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (mac_done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ram_mem.delete(32'h300 + 32'(i));
      model_mem.delete(32'h300 + 32'(i));
    end

    for (int i = 0; i < 64; i++) poke(32'h1000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      poke(32'hFFFF_FFFC + 32'(i), 8'($urandom));
      poke(32'(i), 8'($urandom));
    end
    for (int t = 0; t < 150; t++) rand_txn();
    rdy = 1'b1;
    repeat (4) @(posedge clk);

    foreach (model_mem[ad]) chk("mem_final", 32'(rd_ram(ad)), 32'(model_mem[ad]));
    foreach (ram_mem[ad]) chk("mem_extra", 32'(ram_mem[ad]), 32'(rd_model(ad)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
